half_adder: RTL and testbench
=============================

# half_adder

Registered, lane-parallel half-adder bank. Each lane adds two 1-bit operands and produces a registered sum bit and carry bit one clock after the operands are presented. A saturating counter tracks how many accepted beats produced a carry. The block is a leaf arithmetic primitive for carry-chain and popcount logic; with the default `LANES=1` it is the classic two-input half adder with an output register.

## Interface
Parameters:
- `LANES`, default 1: number of independent half-adder lanes (≥1).
- `CNT_W`, default 16: width of the carry-event counter (≥1).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  input  1: rising-edge clock.
- `rst`  input  1: synchronous, active-high reset.
- `in_valid`  input  1: operands on `in` are valid this cycle.
- `in`  input  2*LANES: operand pairs. Lane i uses `a = in[2i]` and `b = in[2i+1]`.
- `clear_cnt`  input  1: synchronously zeroes `carry_count`.
- `sum`  output  LANES: registered `a ^ b` per lane.
- `carry`  output  LANES: registered `a & b` per lane.
- `out_valid`  output  1: `sum` and `carry` were updated by this cycle's edge.
- `carry_count`  output  CNT_W: number of accepted beats in which any lane had carry=1. Saturates at the maximum value.

## Operation
- Per lane: `{carry, sum} = a + b`, giving 2'b00, 01, 01, 10 for ab = 00, 01, 10, 11.
- Beat accepted (`in_valid=1`):
  - Register all lanes' `sum`/`carry`.
  - `out_valid` becomes 1.
- No beat (`in_valid=0`):
  - `sum`/`carry` hold their previous values.
  - `out_valid` becomes 0.
- Counter:
  - Increments by 1 on an accepted beat where the OR of all lanes' next carry is 1.
  - Holds at 2^CNT_W−1 once it reaches that value; it never wraps.
- `clear_cnt`:
  - Priority over increment: `clear_cnt=1` with a carrying beat leaves the count at 0.
  - Does not affect `sum`, `carry` or `out_valid`.
- Any X or Z on `in` while `in_valid=0` is ignored.

## Timing
- Latency: 1 cycle from `in`/`in_valid` sampled at edge N to `sum`/`carry`/`out_valid` visible after edge N.
- Throughput: one beat per cycle. There is no backpressure and no ready signal.
- Reset (`rst=1` at an edge):
  - `sum=0`, `carry=0`, `out_valid=0`, `carry_count=0`.
  - Reset overrides `in_valid` and `clear_cnt` in the same cycle.
- Reset mid-stream: the beat presented in the reset cycle is dropped. The next cycle operates normally.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Structure
- Sub-module `ha_cell`: purely combinational, ports `a`, `b`, `sum`, `carry`. Instantiate it LANES times with a generate loop.
- The top level holds the output registers, the valid flop and the saturating counter.
- A shared package is not required. If the team's arithmetic package exists, put the counter-max constant `(1<<CNT_W)-1` helper there; otherwise keep it as a localparam.

## Test plan
- Reset, then `rst=0`, `LANES=1`, `in_valid=1` with `in` = 2'b00, 2'b10, 2'b01, 2'b11 on consecutive cycles. Required `{carry,sum}` one cycle later: 00, 01, 01, 10; `out_valid=1` throughout; `carry_count=1`.
- Hold and valid: `in=2'b11` with `in_valid=1`, then `in=2'b00` with `in_valid=0`. Required: `sum=0`, `carry=1` holds, `out_valid` drops to 0, `carry_count` unchanged.
- Saturation: `CNT_W=2`, five beats of `in=2'b11`. Required `carry_count` sequence: 1, 2, 3, 3, 3.
- Clear priority: `carry_count=2`, then `clear_cnt=1` with an `in=2'b11` beat. Required: `carry_count=0`, `carry=1`, `out_valid=1`.
- Multi-lane: `LANES=4`, `in=8'b11_01_10_00`. Required `sum=4'b0110`, `carry=4'b1000`, count +1. A following beat `8'b01_10_01_00` leaves the count unchanged.
- Reset mid-stream: assert `rst` during an `in=2'b11` beat. Required: all outputs 0 after that edge; the next beat `2'b01` gives `sum=1` with normal latency.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared helpers for the half-adder bank: operand bit positions within the
// packed lane input bus.
package half_adder_pkg;

  // Lane i takes its a operand from in[2i] and its b operand from in[2i+1].
  function automatic int unsigned lane_a_idx(input int unsigned lane);
    return 2 * lane;
  endfunction

  function automatic int unsigned lane_b_idx(input int unsigned lane);
    return 2 * lane + 1;
  endfunction

endpackage

// File: rtl/half_adder_ha_cell.sv
// Single combinational half-adder cell: {carry, sum} = a + b.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered lane-parallel half-adder bank with a saturating counter of
// beats in which any lane carried.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2*LANES-1:0]   in,
  input  logic                 clear_cnt,
  output logic [LANES-1:0]     sum,
  output logic [LANES-1:0]     carry,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     carry_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES-1:0] sum_nxt;
  logic [LANES-1:0] carry_nxt;
  logic             any_carry;
  logic             cnt_inc;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ha_cell u_cell (
      .a     (in[lane_a_idx(i)]),
      .b     (in[lane_b_idx(i)]),
      .sum   (sum_nxt[i]),
      .carry (carry_nxt[i])
    );
  end

  assign any_carry = |carry_nxt;
  // in_valid gates first so undriven operands in idle cycles cannot leak in.
  assign cnt_inc   = in_valid && any_carry && (carry_count != CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum         <= '0;
      carry       <= '0;
      out_valid   <= 1'b0;
      carry_count <= '0;
    end else begin
      if (in_valid) begin
        sum   <= sum_nxt;
        carry <= carry_nxt;
      end
      out_valid <= in_valid;
      if (clear_cnt) begin
        carry_count <= '0;
      end else if (cnt_inc) begin
        carry_count <= carry_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// Randomized and directed check of half_adder against an arithmetic model;
// one single-lane instance with a 2-bit counter and one 4-lane instance.
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       clear_cnt;
  logic [7:0] in_b;
  logic [1:0] in_a;

  logic       sum_a, carry_a, vld_a;
  logic [1:0] cnt_a;
  logic [3:0] sum_b, carry_b;
  logic       vld_b;
  logic [3:0] cnt_b;

  int total = 0;
  int bad   = 0;

  logic       m_sum_a, m_carry_a, m_vld;
  logic [3:0] m_sum_b, m_carry_b;
  int         m_cnt_a, m_cnt_b;

  assign in_a = in_b[1:0];

  always #5 clk = ~clk;

  half_adder #(.LANES(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_a), .clear_cnt(clear_cnt),
    .sum(sum_a), .carry(carry_a), .out_valid(vld_a), .carry_count(cnt_a)
  );

  half_adder #(.LANES(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_b), .clear_cnt(clear_cnt),
    .sum(sum_b), .carry(carry_b), .out_valid(vld_b), .carry_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising
  // edge, compare at the next falling edge.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c);
    int  s;
    bit  anyc_a, anyc_b;
    rst = r; in_valid = v; in_b = d; clear_cnt = c;
    @(posedge clk);
    if (r) begin
      m_sum_a = 0; m_carry_a = 0; m_vld = 0;
      m_sum_b = 0; m_carry_b = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      anyc_a = 0; anyc_b = 0;
      if (v) begin
        for (int i = 0; i < 4; i++) begin
          s = int'(d[2*i]) + int'(d[2*i+1]);
          m_sum_b[i]   = (s % 2) == 1;
          m_carry_b[i] = (s / 2) == 1;
          if (s / 2 == 1) anyc_b = 1;
          if (i == 0) begin
            m_sum_a   = m_sum_b[0];
            m_carry_a = m_carry_b[0];
            anyc_a    = anyc_b;
          end
        end
      end
      m_vld = v;
      if (c) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else begin
        if (anyc_a && m_cnt_a < 3)  m_cnt_a++;
        if (anyc_b && m_cnt_b < 15) m_cnt_b++;
      end
    end
    @(negedge clk);
    chk("sum_a",   sum_a,   m_sum_a);
    chk("carry_a", carry_a, m_carry_a);
    chk("vld_a",   vld_a,   m_vld);
    chk("cnt_a",   cnt_a,   m_cnt_a);
    chk("sum_b",   sum_b,   m_sum_b);
    chk("carry_b", carry_b, m_carry_b);
    chk("vld_b",   vld_b,   m_vld);
    chk("cnt_b",   cnt_b,   m_cnt_b);
  endtask

  initial begin
    int sat_seq [5] = '{1, 2, 3, 3, 3};
    logic [1:0] tp_in [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [1:0] tp_cs [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

    // Reset, including reset overriding a valid carrying beat and clear.
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'hff, 1);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_vld", vld_a, 0);

    // Truth table on consecutive beats.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, {6'b0, tp_in[i]}, 0);
      chk("tt_cs",  {carry_a, sum_a}, tp_cs[i]);
      chk("tt_vld", vld_a, 1);
    end
    chk("tt_cnt", cnt_a, 1);

    // Hold while idle.
    step(0, 1, 8'h03, 0);
    step(0, 0, 8'h00, 0);
    chk("hold_carry", carry_a, 1);
    chk("hold_sum",   sum_a,   0);
    chk("hold_vld",   vld_a,   0);
    chk("hold_cnt",   cnt_a,   2);

    // Saturation of the 2-bit counter.
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h03, 0);
      chk("sat_cnt", cnt_a, sat_seq[i]);
    end

    // Clear wins over a carrying beat.
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h03, 0);
    chk("clr_pre", cnt_a, 2);
    step(0, 1, 8'h03, 1);
    chk("clr_cnt",   cnt_a,   0);
    chk("clr_carry", carry_a, 1);
    chk("clr_vld",   vld_a,   1);

    // Multi-lane beats.
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'b11_01_10_00, 0);
    chk("ml_sum",   sum_b,   4'b0110);
    chk("ml_carry", carry_b, 4'b1000);
    chk("ml_cnt",   cnt_b,   1);
    step(0, 1, 8'b01_10_01_00, 0);
    chk("ml_cnt2",  cnt_b,   1);

    // Reset mid-stream drops the beat; the next beat is normal.
    step(0, 1, 8'h03, 0);
    step(1, 1, 8'h03, 0);
    chk("rm_cs",  {carry_a, sum_a}, 0);
    chk("rm_vld", vld_a, 0);
    chk("rm_cnt", cnt_a, 0);
    step(0, 1, 8'h01, 0);
    chk("rm_sum", sum_a, 1);
    chk("rm_v1",  vld_a, 1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom % 60) == 0, ($urandom % 4) != 0, 8'($urandom),
           ($urandom % 20) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
